serial_parity_rx: RTL and testbench

Serial frame receiver that checks parity, the receive end of the team's XOR parity generator and serial transmitter path. It deserialises an asynchronous-style frame (start, data LSB-first, parity, stop) from a single-bit line oversampled by the system clock. A running XOR over data and parity bits flags parity errors. It sits between an external serial pin and byte-wide consumer logic.

---
 rtl/serial_parity_rx_if.sv | 32 +++
 rtl/serial_parity_rx.sv | 149 ++++++++++++++
 tb/tb_serial_parity_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_rx_if.sv
// serial_parity_rx_if
//   Bundle between a serial pin, the parity-checking receiver and the
//   byte-wide consumer.
//   master : receiver side. It reads rx and drives the result signals.
//   slave  : pin/consumer side. It drives rx and reads the results.
//   Signals:
//     rx          serial line, idles high
//     data_out    last received data word (DATA_BITS wide)
//     valid       one-cycle pulse when data_out and the error flags update
//     parity_err  parity mismatch on the last frame
//     frame_err   stop bit sampled low on the last frame
//     busy        a frame is in progress
interface serial_parity_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output data_out, valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx,
    input  data_out, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_parity_rx.sv
// serial_parity_rx
//   Receives one serial frame (start, DATA_BITS data LSB first, parity, stop)
//   that is oversampled by clk at CLKS_PER_BIT cycles per bit. Each bit is
//   sampled mid-bit. A running XOR checks parity, and the stop bit is checked
//   for a framing error. The data word, parity_err and frame_err update
//   together with a one-cycle valid pulse on the cycle after the stop sample.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_parity_rx_if.master (rx in; data_out/valid/parity_err/
//            frame_err/busy out)
//   Optional feature (macro RX_SYNC_EN): rx passes through a two-flop
//   synchroniser before the FSM. All sample points and valid move 2 cycles
//   later relative to the pin.
module serial_parity_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  serial_parity_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 3);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_DONE  = IW'(DATA_BITS + 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS:0]   shift_in;
  logic                 acc;
  logic                 stop_low;
  logic                 rx_s;
  logic                 tick;
  logic                 done;

`ifdef RX_SYNC_EN
  logic rx_p0, rx_p1;

  // synchroniser stage: pin -> rx_p0 -> rx_p1 -> FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rx_s = rx_p1;
`else
  assign rx_s = bus.rx;
`endif

  // The counter is preloaded to half a bit on the start edge, so the same
  // wrap point gives the mid-bit sample for the start bit and all later bits.
  assign tick     = (cnt == CNT_LAST);
  assign shift_in = {rx_s, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (tick && (idx == IDX_LAST)) state_nxt = PARITY;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx reaches IDX_DONE after the stop sample. That extra STOP cycle is
  // the completion cycle, so busy drops together with the valid pulse.
  always_comb begin
    bus.busy = (state != IDLE);
    done     = (state == STOP) && (idx == IDX_DONE);
  end

  // Bit timing, shift register and parity accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      acc      <= 1'b0;
      stop_low <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cnt <= CNT_HALF;
        idx <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (tick) begin
        unique case (state)
          START: begin
            acc <= ODD_PARITY;
            idx <= '0;
          end
          DATA: begin
            // Shift in from the top. After DATA_BITS samples, bit 0 holds
            // the first (LSB) bit received.
            shreg <= shift_in[DATA_BITS:1];
            acc   <= acc ^ rx_s;
            idx   <= idx + 1'b1;
          end
          PARITY: begin
            acc <= acc ^ rx_s;
            idx <= idx + 1'b1;
          end
          STOP: begin
            stop_low <= ~rx_s;
            idx      <= idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Result registers: flags hold until the next completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid      <= 1'b0;
      bus.data_out   <= '0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.valid <= done;
      if (done) begin
        bus.data_out   <= shreg;
        bus.parity_err <= acc;
        bus.frame_err  <= stop_low;
      end
    end
  end
endmodule

// File: tb/tb_serial_parity_rx.sv
`timescale 1ns/1ps
module tb_serial_parity_rx;
  localparam int DB  = 8;
  localparam int CPB = 4;
`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Cycles from the first edge that sees the start bit to the edge that
  // raises valid: half a bit, then DATA_BITS+2 bit times, then the completion cycle.
  localparam int LAT = CPB/2 + (DB + 2)*CPB + 1 + SYNC_LAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  always #5 clk = ~clk;

  serial_parity_rx_if #(.DATA_BITS(DB)) bus_e ();
  serial_parity_rx_if #(.DATA_BITS(DB)) bus_o ();
  assign bus_e.rx = rx;
  assign bus_o.rx = rx;

  serial_parity_rx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(bus_e));
  serial_parity_rx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bus(bus_o));

  typedef struct {
    logic [DB-1:0] d;
    bit            pe;
    bit            fe;
    int            at;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  exp_t last_e, last_o;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic [DB+2:0] pbits;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_one(input bit odd, input logic v, input logic [DB-1:0] d,
                         input logic pe, input logic fe);
    exp_t e;
    string tag;
    tag = odd ? "odd" : "even";
    if (v !== 1'b1) return;
    if ((odd && q_o.size() == 0) || (!odd && q_e.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_valid_%s: valid=1 with no frame expected (cycle %0d)", tag, cyc);
      return;
    end
    e = odd ? q_o.pop_front() : q_e.pop_front();
    chk({"data_", tag}, d, e.d);
    chk({"parity_err_", tag}, pe, e.pe);
    chk({"frame_err_", tag}, fe, e.fe);
    chk({"valid_cycle_", tag}, cyc, e.at);
  endtask

  // Monitor: pops and compares whenever a receiver presents valid
  always @(negedge clk) begin
    if (rst_n) begin
      mon_one(1'b0, bus_e.valid, bus_e.data_out, bus_e.parity_err, bus_e.frame_err);
      mon_one(1'b1, bus_o.valid, bus_o.data_out, bus_o.parity_err, bus_o.frame_err);
    end
  end

  // Reference: a frame carries data d, parity bit p and stop bit s. The
  // parity error is set when the XOR of d and p differs from the mode
  // (0 even, 1 odd). The frame error is set when the stop bit is 0.
  // Call at a negedge; returns at the negedge after the stop bit.
  task automatic send(input logic [DB-1:0] d, input bit p, input bit s, input bit noise);
    logic [DB+2:0] bits;
    exp_t e;
    int   t0;
    bits = {s, p, d, 1'b0};
    t0   = cyc + 1;
    e.d  = d;
    e.fe = (s == 1'b0);
    e.at = t0 + LAT;
    e.pe = (((^d) ^ p) != 1'b0);
    q_e.push_back(e);
    last_e = e;
    e.pe = (((^d) ^ p) != 1'b1);
    q_o.push_back(e);
    last_o = e;
    for (int k = 0; k < DB + 3; k++) begin
      for (int j = 0; j < CPB; j++) begin
        // Data/parity bits may wiggle away from the mid-bit sample point.
        if (noise && k > 0 && k < DB + 2 && j != CPB/2 && $urandom_range(0, 1) == 1)
          rx = ~bits[k];
        else
          rx = bits[k];
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({"zero_data_e_", tag}, bus_e.data_out, 0);
    chk({"zero_valid_e_", tag}, bus_e.valid, 0);
    chk({"zero_perr_e_", tag}, bus_e.parity_err, 0);
    chk({"zero_ferr_e_", tag}, bus_e.frame_err, 0);
    chk({"zero_busy_e_", tag}, bus_e.busy, 0);
    chk({"zero_data_o_", tag}, bus_o.data_out, 0);
    chk({"zero_valid_o_", tag}, bus_o.valid, 0);
    chk({"zero_perr_o_", tag}, bus_o.parity_err, 0);
    chk({"zero_ferr_o_", tag}, bus_o.frame_err, 0);
    chk({"zero_busy_o_", tag}, bus_o.busy, 0);
  endtask

  task automatic chk_hold(input string tag);
    chk({"hold_busy_e_", tag}, bus_e.busy, 0);
    chk({"hold_data_e_", tag}, bus_e.data_out, last_e.d);
    chk({"hold_perr_e_", tag}, bus_e.parity_err, last_e.pe);
    chk({"hold_ferr_e_", tag}, bus_e.frame_err, last_e.fe);
    chk({"hold_data_o_", tag}, bus_o.data_out, last_o.d);
    chk({"hold_perr_o_", tag}, bus_o.parity_err, last_o.pe);
    chk({"hold_ferr_o_", tag}, bus_o.frame_err, last_o.fe);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] d;
    bit p, s;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Directed frames
    send(8'hA5, 1'b0, 1'b1, 1'b0); idle(4);
    send(8'h01, 1'b0, 1'b1, 1'b0); idle(4);
    send(8'h3C, 1'b0, 1'b0, 1'b0); idle(4);
    chk_hold("after_ferr");
    send(8'hC3, 1'b0, 1'b1, 1'b0); idle(4);
    send(8'h3C, 1'b0, 1'b0, 1'b0); idle(4 + SYNC_LAT);

    // One-cycle low glitch: busy pulses, no valid, flags held
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (SYNC_LAT) @(negedge clk);
    chk("glitch_busy_e", bus_e.busy, 1);
    chk("glitch_busy_o", bus_o.busy, 1);
    idle(CPB + 2);
    chk_hold("glitch");

    // Reset asserted during data bit 3 of a frame
    pbits = {1'b1, 1'b0, 8'h96, 1'b0};
    for (int c = 0; c < 4*CPB + CPB/2 + 1; c++) begin
      rx = pbits[c / CPB];
      @(negedge clk);
    end
    chk("midframe_busy_e", bus_e.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midframe_reset");
    last_e = '{d: '0, pe: 1'b0, fe: 1'b0, at: 0};
    last_o = last_e;
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send(8'h5A, 1'b0, 1'b1, 1'b0); idle(4 + SYNC_LAT);

    // Back-to-back frames
    send(8'hFF, 1'b0, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1, 1'b0);
    idle(4 + SYNC_LAT);

    // Randomised frames with mid-bit noise and random gaps (including none)
    for (int n = 0; n < 40; n++) begin
      d = DB'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) != 0);
      send(d, p, s, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(LAT + 4);

    n_chk++;
    if (q_e.size() != 0 || q_o.size() != 0) begin
      n_fail++;
      $display("FAIL missing_valid: pending even=%0d odd=%0d expected 0", q_e.size(), q_o.size());
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
